// File: rtl/mem_loader_ctrl.sv
// mem_loader_ctrl
//   Run controller placed in front of the processor core and its data memory.
//   A host request starts a run: an input image is streamed byte-by-byte into
//   dat_mem while the core is held in reset, the core is then released and its
//   RUN cycles are counted until core_done or MAX_CYCLES, and finally a result
//   window is streamed back out of dat_mem before done is raised.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   req                    host start request (honoured in IDLE and FINISH only)
//   in_valid/in_ready/in_data     byte-wide load stream into dat_mem
//   out_valid/out_ready/out_data  byte-wide result stream out of dat_mem
//   mem_sel                1 = this block owns the dat_mem port, 0 = core owns it
//   mem_wr_en/mem_addr/mem_wr_data/mem_rd_data   dat_mem port (combinational read)
//   core_reset, core_done  core reset control and completion flag
//   busy, done             run in progress / run finished
//   timeout                sticky: last run stopped on MAX_CYCLES
//   cycle_count            RUN cycles of the last or current run
module mem_loader_ctrl #(
  parameter int unsigned AW         = 8,
  parameter int unsigned CW         = 16,
  parameter int unsigned LOAD_LEN   = 64,
  parameter int unsigned DUMP_BASE  = 64,
  parameter int unsigned DUMP_LEN   = 64,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam int unsigned LOAD_LAST_I = LOAD_LEN - 1;
  localparam int unsigned DUMP_LAST_I = DUMP_LEN - 1;
  localparam int unsigned MAX_LAST_I  = MAX_CYCLES - 1;
  localparam int unsigned DUMP_BASE_I = DUMP_BASE;

  localparam logic [AW:0]   LOAD_LAST = LOAD_LAST_I[AW:0];
  localparam logic [AW:0]   DUMP_LAST = DUMP_LAST_I[AW:0];
  localparam logic [CW-1:0] MAX_LAST  = MAX_LAST_I[CW-1:0];
  localparam logic [AW-1:0] BASE_ADDR = DUMP_BASE_I[AW-1:0];

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP,
    FINISH
  } state_t;

  state_t        state;
  // One bit wider than the address so a full 2^AW transfer length is countable.
  logic [AW:0]   idx;
  logic [AW-1:0] dump_addr;

  // Sum is truncated to AW bits, so the result window wraps past the top address.
  assign dump_addr = BASE_ADDR + idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (req) begin
            state       <= LOAD;
            idx         <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        LOAD: begin
          // in_ready is constantly high in LOAD, so in_valid alone is the accept.
          if (in_valid) begin
            idx <= idx + 1'b1;
            if (idx == LOAD_LAST) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // Exit happens no later than MAX_CYCLES-1 -> MAX_CYCLES, so no wrap.
          cycle_count <= cycle_count + 1'b1;
          if (core_done) begin
            state <= DUMP;
            idx   <= '0;
          end else if (cycle_count == MAX_LAST) begin
            state   <= DUMP;
            idx     <= '0;
            timeout <= 1'b1;
          end
        end
        DUMP: begin
          if (out_ready) begin
            idx <= idx + 1'b1;
            if (idx == DUMP_LAST) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    mem_sel     = 1'b1;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    core_reset  = 1'b1;
    case (state)
      LOAD: begin
        in_ready    = 1'b1;
        mem_wr_en   = in_valid;
        mem_addr    = idx[AW-1:0];
        mem_wr_data = in_data;
      end
      RUN: begin
        mem_sel    = 1'b0;
        core_reset = 1'b0;
      end
      DUMP: begin
        out_valid = 1'b1;
        out_data  = mem_rd_data;
        mem_addr  = dump_addr;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// tb_mem_loader_ctrl
//   Self-checking bench for mem_loader_ctrl. Two instances run in lockstep on
//   the same stimulus: dut (DUMP_BASE=8) and dut_w (DUMP_BASE=255, exercising
//   result-window address wrap). Each has its own behavioural dat_mem muxed
//   between the controller and a small core model on mem_sel.
module tb_mem_loader_ctrl;

  logic       clk;
  logic       reset;
  logic       req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       core_done;

  logic        in_ready, out_valid, mem_sel, mem_wr_en, core_reset, busy, done, timeout;
  logic [7:0]  out_data, mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0] cycle_count;

  logic        w_in_ready, w_out_valid, w_mem_sel, w_mem_wr_en, w_core_reset, w_busy, w_done, w_timeout;
  logic [7:0]  w_out_data, w_mem_addr, w_mem_wr_data, w_mem_rd_data;
  logic [15:0] w_cycle_count;

  // Core model write port (applied only while the core owns the memory).
  logic       core_we;
  logic [7:0] core_addr, core_wdata, core_addr_w, core_wdata_w;

  logic [7:0] mem   [256];
  logic [7:0] mem_w [256];

  logic [15:0] exp_wr [$];
  logic [7:0]  exp_out [$];
  logic [7:0]  exp_w [$];

  int passed = 0;
  int total  = 0;

  mem_loader_ctrl #(
    .AW(8), .CW(16), .LOAD_LEN(4), .DUMP_BASE(8), .DUMP_LEN(2), .MAX_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .core_reset(core_reset), .core_done(core_done),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  mem_loader_ctrl #(
    .AW(8), .CW(16), .LOAD_LEN(4), .DUMP_BASE(255), .DUMP_LEN(2), .MAX_CYCLES(20)
  ) dut_w (
    .clk(clk), .reset(reset), .req(req),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(out_ready),
    .mem_sel(w_mem_sel), .mem_wr_en(w_mem_wr_en), .mem_addr(w_mem_addr),
    .mem_wr_data(w_mem_wr_data), .mem_rd_data(w_mem_rd_data),
    .core_reset(w_core_reset), .core_done(core_done),
    .busy(w_busy), .done(w_done), .timeout(w_timeout), .cycle_count(w_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data   = mem[mem_addr];
  assign w_mem_rd_data = mem_w[w_mem_addr];

  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end else if (core_we) begin
      mem[core_addr] <= core_wdata;
    end
    if (w_mem_sel) begin
      if (w_mem_wr_en) mem_w[w_mem_addr] <= w_mem_wr_data;
    end else if (core_we) begin
      mem_w[core_addr_w] <= core_wdata_w;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  int          beat = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr, prev_data;
  logic [15:0] e_wr;
  logic [7:0]  e_b;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en) begin
        total++;
        if (exp_wr.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wr_data);
        end else begin
          e_wr = exp_wr.pop_front();
          if ({mem_addr, mem_wr_data} !== e_wr)
            $display("FAIL load_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     mem_addr, mem_wr_data, e_wr[15:8], e_wr[7:0]);
          else passed++;
        end
      end
      if (in_ready && !in_valid) begin
        total++;
        if (mem_wr_en !== 1'b0) $display("FAIL stall_write: got wr_en=%b, required 0", mem_wr_en);
        else passed++;
      end
      if (!in_ready) begin
        total++;
        if (mem_wr_en !== 1'b0) $display("FAIL wr_outside_load: got wr_en=%b, required 0", mem_wr_en);
        else passed++;
      end
      if (out_valid && prev_stall) begin
        total++;
        if ({mem_addr, out_data} !== {prev_addr, prev_data})
          $display("FAIL dump_hold: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, out_data, prev_addr, prev_data);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_out.size() == 0) begin
          $display("FAIL unexpected_out: got data=%h, required no beat", out_data);
        end else begin
          e_b = exp_out.pop_front();
          if ({mem_addr, out_data} !== {8'(8 + beat), e_b})
            $display("FAIL dump_beat: got addr=%0d data=%h, required addr=%0d data=%h",
                     mem_addr, out_data, 8'(8 + beat), e_b);
          else passed++;
        end
        total++;
        if (exp_w.size() == 0) begin
          $display("FAIL unexpected_wrap_out: got data=%h, required no beat", w_out_data);
        end else begin
          e_b = exp_w.pop_front();
          if ({w_out_valid, w_mem_addr, w_out_data} !== {1'b1, 8'(255 + beat), e_b})
            $display("FAIL wrap_beat: got valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                     w_out_valid, w_mem_addr, w_out_data, 8'(255 + beat), e_b);
          else passed++;
        end
        beat++;
      end
      if (!out_valid) beat = 0;
      prev_stall = out_valid && !out_ready;
      prev_addr  = mem_addr;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
      beat       = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
  endtask

  // One complete run: request, load 4 bytes, core model, dump 2 bytes, checks.
  task automatic do_run(input bit vtog, input bit rtog, input bit req_noise,
                        input int done_after, input logic [7:0] b0, input logic [7:0] b1,
                        input int exp_cc, input bit exp_to);
    logic [7:0] pat [4];
    int i, c, n, k;
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    req = 1'b1;
    tick();
    req = req_noise;
    total++;
    if ({busy, in_ready, timeout, done} !== 4'b1100)
      $display("FAIL load_entry: got busy/in_ready/timeout/done=%b, required 1100", {busy, in_ready, timeout, done});
    else passed++;
    total++;
    if (cycle_count !== 16'd0) $display("FAIL count_clear: got %0d, required 0", cycle_count);
    else passed++;

    i = 0;
    c = 0;
    while (i < 4 && c < 50) begin
      in_valid = vtog ? (c % 2 == 0) : 1'b1;
      in_data  = pat[i];
      if (in_valid) exp_wr.push_back({i[7:0], pat[i]});
      tick();
      if (in_valid) i++;
      c++;
    end
    in_valid = 1'b0;
    total++;
    if (i != 4) $display("FAIL load_budget: got %0d bytes, required 4", i);
    else passed++;

    total++;
    if ({core_reset, mem_sel, in_ready, busy} !== 4'b0001)
      $display("FAIL run_entry: got core_reset/mem_sel/in_ready/busy=%b, required 0001",
               {core_reset, mem_sel, in_ready, busy});
    else passed++;

    n = 0;
    while (core_reset === 1'b0 && n < 100) begin
      n++;
      core_we      = (n <= 2);
      core_addr    = (n == 1) ? 8'd8 : 8'd9;
      core_wdata   = (n == 1) ? b0 : b1;
      core_addr_w  = (n == 1) ? 8'd255 : 8'd0;
      core_wdata_w = (n == 1) ? ~b0 : ~b1;
      if (n <= 2) begin
        exp_out.push_back(core_wdata);
        exp_w.push_back(core_wdata_w);
      end
      core_done = (n == done_after);
      tick();
    end
    core_we   = 1'b0;
    core_done = 1'b0;
    total++;
    if (n != exp_cc) $display("FAIL run_cycles: got %0d core_reset-low cycles, required %0d", n, exp_cc);
    else passed++;

    k = 0;
    while (done !== 1'b1 && k < 50) begin
      out_ready = rtog ? k[0] : 1'b1;
      tick();
      k++;
    end
    req       = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({done, busy, core_reset, out_valid} !== 4'b1010)
      $display("FAIL finish_state: got done/busy/core_reset/out_valid=%b, required 1010",
               {done, busy, core_reset, out_valid});
    else passed++;
    total++;
    if (cycle_count !== 16'(exp_cc)) $display("FAIL cycle_count: got %0d, required %0d", cycle_count, exp_cc);
    else passed++;
    total++;
    if (timeout !== exp_to) $display("FAIL timeout: got %b, required %b", timeout, exp_to);
    else passed++;
    total++;
    if ({w_done, w_timeout, w_cycle_count} !== {1'b1, exp_to, 16'(exp_cc)})
      $display("FAIL wrap_finish: got done=%b timeout=%b count=%0d, required done=1 timeout=%b count=%0d",
               w_done, w_timeout, w_cycle_count, exp_to, exp_cc);
    else passed++;
    total++;
    if (exp_wr.size() + exp_out.size() + exp_w.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d pending, required 0/0/0",
               exp_wr.size(), exp_out.size(), exp_w.size());
    else passed++;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({core_reset, mem_sel, mem_wr_en, in_ready, out_valid, done, busy, timeout} !== 8'b11000000)
      $display("FAIL reset_outputs: got %b, required 11000000",
               {core_reset, mem_sel, mem_wr_en, in_ready, out_valid, done, busy, timeout});
    else passed++;
    total++;
    if (cycle_count !== 16'd0) $display("FAIL reset_count: got %0d, required 0", cycle_count);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_run;
    do_run(1'b0, 1'b0, 1'b0, 5, 8'hA5, 8'h5A, 5, 1'b0);
  endtask

  task automatic test_backpressure;
    do_run(1'b1, 1'b1, 1'b1, 5, 8'h96, 8'h69, 5, 1'b0);
  endtask

  task automatic test_timeout;
    do_run(1'b0, 1'b0, 1'b0, 0, 8'h3C, 8'hC3, 20, 1'b1);
    core_done = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if ({done, busy, timeout, cycle_count} !== {3'b101, 16'd20})
      $display("FAIL finish_ignores_core_done: got done=%b busy=%b timeout=%b count=%0d, required 1 0 1 20",
               done, busy, timeout, cycle_count);
    else passed++;
    core_done = 1'b0;
  endtask

  task automatic test_restart;
    do_run(1'b0, 1'b0, 1'b0, 5, 8'h12, 8'h34, 5, 1'b0);
  endtask

  task automatic test_collision;
    do_run(1'b0, 1'b0, 1'b0, 20, 8'h5F, 8'hF5, 20, 1'b0);
  endtask

  task automatic test_address_wrap;
    do_run(1'b0, 1'b1, 1'b0, 3, 8'hE1, 8'h1E, 3, 1'b0);
  endtask

  task automatic test_mid_reset;
    req = 1'b1;
    tick();
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_data  = 8'hB0 + 8'(j);
      exp_wr.push_back({8'(j), in_data});
      tick();
    end
    in_valid = 1'b0;
    total++;
    if ({busy, in_ready} !== 2'b11) $display("FAIL req_ignored_in_load: got busy/in_ready=%b, required 11", {busy, in_ready});
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if ({core_reset, mem_sel, mem_wr_en, in_ready, out_valid, done, busy, timeout, cycle_count} !== {8'b11000000, 16'd0})
      $display("FAIL mid_reset_outputs: got %b count=%0d, required 11000000 count=0",
               {core_reset, mem_sel, mem_wr_en, in_ready, out_valid, done, busy, timeout}, cycle_count);
    else passed++;
    req      = 1'b0;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    total++;
    if ({busy, in_ready, exp_wr.size() == 0} !== 3'b001)
      $display("FAIL idle_after_reset: got busy/in_ready=%b pending=%0d, required 00 pending=0",
               {busy, in_ready}, exp_wr.size());
    else passed++;
  endtask

  initial begin
    reset        = 1'b1;
    req          = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    core_done    = 1'b0;
    core_we      = 1'b0;
    core_addr    = '0;
    core_wdata   = '0;
    core_addr_w  = '0;
    core_wdata_w = '0;

    test_reset();
    test_basic_run();
    test_backpressure();
    test_timeout();
    test_restart();
    test_collision();
    test_address_wrap();
    test_mid_reset();
    test_back_to_back();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic test_back_to_back;
    do_run(1'b0, 1'b0, 1'b0, 4, 8'h81, 8'h18, 4, 1'b0);
    do_run(1'b1, 1'b0, 1'b0, 6, 8'h42, 8'h24, 6, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/mem_loader_ctrl.md
# mem_loader_ctrl

Run controller that sits upstream of the processor core and its data memory. It handles the host handshake (`req`), streams an input image into `dat_mem` through a byte-wide valid/ready port, and holds the core in reset while loading. It then releases the core, counts cycles until `core_done` or a timeout, and streams a result window back out of `dat_mem` before reporting `done`.

## Interface
- `AW`, 8: data-memory address width.
- `CW`, 16: cycle-counter width.
- `LOAD_LEN`, 64: bytes loaded to addresses 0..LOAD_LEN-1; legal range 1..2^AW.
- `DUMP_BASE`, 64: first address of the result window.
- `DUMP_LEN`, 64: bytes streamed out; legal range 1..2^AW.
- `MAX_CYCLES`, 4096: RUN-cycle limit before timeout; must be ≥1 and < 2^CW.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  start request from host; sampled only in IDLE and FINISH.
- `in_valid`  in  1  load byte valid.
- `in_data`  in  8  load byte.
- `in_ready`  out  1  load byte accepted when high together with `in_valid`.
- `out_valid`  out  1  result byte valid.
- `out_data`  out  8  result byte.
- `out_ready`  in  1  host accepts result byte.
- `mem_sel`  out  1  1 = this block owns the dat_mem port; 0 = core owns it. The top level muxes on this.
- `mem_wr_en`  out  1  dat_mem write strobe.
- `mem_addr`  out  AW  dat_mem address.
- `mem_wr_data`  out  8  dat_mem write data.
- `mem_rd_data`  in  8  dat_mem combinational read data.
- `core_reset`  out  1  reset to PC/core.
- `core_done`  in  1  core completion flag.
- `busy`  out  1  high in LOAD, RUN, DUMP.
- `done`  out  1  high in FINISH.
- `timeout`  out  1  sticky; the last run hit MAX_CYCLES.
- `cycle_count`  out  CW  RUN cycles of the last or current run.

## Operation
- States: IDLE, LOAD, RUN, DUMP, FINISH.
- Internal index `idx` is AW+1 bits wide.
- Reset, from any state at any time: state → IDLE, `idx`=0. Output reset values:
  - `core_reset`=1, `mem_sel`=1
  - `mem_wr_en`=0, `in_ready`=0, `out_valid`=0
  - `done`=0, `busy`=0, `timeout`=0, `cycle_count`=0
  - A reset mid-LOAD or mid-DUMP abandons the transfer with no further writes.
- **IDLE:** `core_reset`=1, `mem_sel`=1. On `req`=1: go to LOAD, clear `idx`, `timeout`, `cycle_count`.
- **LOAD:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, in the same cycle: `mem_wr_en`=1, `mem_addr`=`idx`[AW-1:0], `mem_wr_data`=`in_data`; `idx`++.
  - When the accepted byte has `idx`==LOAD_LEN-1, go to RUN.
  - `in_valid`=0 stalls indefinitely with no write.
- **RUN:**
  - `mem_sel`=0, `core_reset`=0, `in_ready`=0.
  - `cycle_count` increments every RUN cycle.
  - `core_done`=1 → DUMP.
  - Else if `cycle_count`==MAX_CYCLES-1 → DUMP with `timeout`←1.
  - If both occur in the same cycle, `core_done` wins and `timeout` stays 0.
  - `idx` is cleared on exit.
- **DUMP:**
  - `core_reset`=1, `mem_sel`=1.
  - `mem_addr`=(DUMP_BASE+`idx`) mod 2^AW, so the address wraps past 2^AW-1.
  - `out_valid`=1; `out_data`=`mem_rd_data`, combinational pass-through.
  - On `out_valid`&`out_ready`: `idx`++. On the last byte (`idx`==DUMP_LEN-1) → FINISH.
  - While `out_ready`=0, address and data hold stable.
- **FINISH:** `done`=1, `core_reset`=1. `timeout` and `cycle_count` hold. `req`=1 → LOAD, with the same clears as IDLE.
- `req` is ignored in LOAD, RUN and DUMP.
- `mem_wr_en` is never 1 outside LOAD.

## Timing
- All state, `idx`, `cycle_count` and `timeout` are registered on the posedge of `clk`. Handshake outputs, `mem_*` and `core_reset` are decoded from the current state and inputs.
- `req` high at edge n → LOAD from cycle n+1; first write can occur in cycle n+1.
- Load throughput is 1 byte/cycle. The last accept at edge m → RUN in cycle m+1, which is the first cycle with `core_reset`=0.
- `core_done` sampled high at edge k → DUMP in cycle k+1. `cycle_count` includes cycle k.
- Dump throughput is 1 byte/cycle with `out_ready` held high. The last accept at edge j → `done`=1 from cycle j+1.
- `cycle_count` maximum value is MAX_CYCLES, reached on timeout. It never wraps.

## Test plan
Settings for all scenarios unless stated: LOAD_LEN=4, DUMP_BASE=8, DUMP_LEN=2, MAX_CYCLES=20.
- **Basic run.** Reset, `req` pulse, stream 0x11,0x22,0x33,0x44 with `in_valid` held high; model core writes 0xA5 to addr 8 and 0x5A to addr 9, then raises `core_done` after 5 RUN cycles. Expected:
  - writes at addresses 0..3, one per cycle;
  - `core_reset` low for exactly 5 cycles;
  - out bytes 0xA5, 0x5A;
  - `done`=1, `cycle_count`=5, `timeout`=0.
- **Backpressure.** Toggle `in_valid` 1,0,1,0… and `out_ready` 0,1,0,1… Expected:
  - no write when `in_valid`=0;
  - `mem_addr` and `out_data` stable while stalled;
  - the same 4 addresses and 2 output bytes as the basic run, with none duplicated or dropped.
- **Timeout.** `core_done` held at 0. Expected:
  - DUMP entered after 20 RUN cycles;
  - `timeout`=1, `cycle_count`=20;
  - `core_done` then raised in FINISH is ignored.
- **Timeout/done collision.** `core_done` rises exactly in RUN cycle 20. Expected: `timeout`=0, `cycle_count`=20.
- **Address wrap.** With DUMP_BASE=255, DUMP_LEN=2: `mem_addr` in DUMP is 255 then 0.
- **Mid-operation reset and restart.**
  - `reset` after 2 of 4 load bytes: IDLE next cycle with all reset values; `req` pulses during LOAD have no effect.
  - `req` in FINISH restarts a full run, with `timeout` and `cycle_count` cleared.
